// File: rtl/locked_reg_access_ctrl.sv
// locked_reg_access_ctrl: key-sequence protected register with round-robin
// two-requester access, idle auto-relock, sticky hard lock and violation count.
module locked_reg_access_ctrl #(
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter logic [7:0]  KEY0      = 8'hA5,
    parameter logic [7:0]  KEY1      = 8'h5A,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  key_i,
    input  logic [15:0] data_i,
    input  logic        hard_lock_i,
    output logic [1:0]  gnt_o,
    output logic [7:0]  reg_q_o,
    output logic        locked_o,
    output logic        hard_locked_o,
    output logic        violation_o,
    output logic [7:0]  viol_cnt_o
);
    typedef enum logic [1:0] {LOCKED, ARMED, UNLOCKED} state_e;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d, reg_q, reg_d, cnt_q, cnt_d;
    logic       ptr_q, ptr_d, hard_q, hard_d, viol_q, viol_d;
    logic       sel, any, key;
    logic [7:0] data;

    assign gnt_o = (req_i == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_i;
    assign sel   = gnt_o[1];
    assign any   = |req_i;
    assign key   = key_i[sel];
    assign data  = sel ? data_i[15:8] : data_i[7:0];
    assign ptr_d = any ? ~sel : ptr_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        reg_d   = reg_q;
        viol_d  = 1'b0;
        hard_d  = hard_q | hard_lock_i;
        // A hard lock in the same cycle as a grant wins over whatever the grant wanted.
        if (hard_d) begin
            state_d = LOCKED;
            timer_d = 8'd0;
            viol_d  = any;
        end else if (any) begin
            case (state_q)
                LOCKED: begin
                    if (key && data == KEY0) state_d = ARMED;
                    else viol_d = 1'b1;
                end
                ARMED: begin
                    state_d = (key && data == KEY1) ? UNLOCKED : LOCKED;
                    timer_d = (key && data == KEY1) ? 8'(TIMEOUT) : 8'd0;
                    viol_d  = !(key && data == KEY1);
                end
                default: begin
                    state_d = key ? LOCKED : UNLOCKED;
                    timer_d = key ? 8'd0 : 8'(TIMEOUT);
                    reg_d   = key ? reg_q : data;
                end
            endcase
        end else if (state_q == UNLOCKED) begin
            timer_d = timer_q - 8'd1;
            state_d = (timer_q == 8'd1) ? LOCKED : UNLOCKED;
        end
        cnt_d = (viol_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOCKED;
            timer_q <= 8'd0;
            reg_q   <= RESET_VAL;
            cnt_q   <= 8'd0;
            ptr_q   <= 1'b0;
            hard_q  <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            hard_q  <= hard_d;
            viol_q  <= viol_d;
        end
    end

    assign reg_q_o       = reg_q;
    assign locked_o      = state_q != UNLOCKED;
    assign hard_locked_o = hard_q;
    assign violation_o   = viol_q;
    assign viol_cnt_o    = cnt_q;
endmodule

// File: tb/tb_locked_reg_access_ctrl.sv
// tb_locked_reg_access_ctrl: directed bench for locked_reg_access_ctrl with
// hand-computed expectations, default parameters (TIMEOUT = 16).
module tb_locked_reg_access_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  key_i = 2'b00;
    logic [15:0] data_i = 16'h0000;
    logic        hard_lock_i = 1'b0;
    logic [1:0]  gnt_o;
    logic [7:0]  reg_q_o;
    logic        locked_o;
    logic        hard_locked_o;
    logic        violation_o;
    logic [7:0]  viol_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    locked_reg_access_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .key_i(key_i),
        .data_i(data_i), .hard_lock_i(hard_lock_i), .gnt_o(gnt_o),
        .reg_q_o(reg_q_o), .locked_o(locked_o), .hard_locked_o(hard_locked_o),
        .violation_o(violation_o), .viol_cnt_o(viol_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One granted transaction from a single requester; outputs checked after the edge.
    task automatic txn(input int n, input logic k, input logic [7:0] d);
        req_i = 2'b01 << n;
        key_i[n] = k;
        data_i[8*n +: 8] = d;
        #1;
        chk("gnt_single", 16'(gnt_o), 16'(2'b01 << n));
        step();
        req_i = 2'b00;
    endtask

    task automatic chk_reset();
        chk("rst_reg", 16'(reg_q_o), 16'h00);
        chk("rst_locked", 16'(locked_o), 16'd1);
        chk("rst_hard", 16'(hard_locked_o), 16'd0);
        chk("rst_viol", 16'(violation_o), 16'd0);
        chk("rst_cnt", 16'(viol_cnt_o), 16'd0);
    endtask

    initial begin
        #12;
        chk_reset();
        step();
        rst_ni = 1'b1;
        step();

        // Full unlock sequence then a data write
        txn(0, 1'b1, 8'hA5);
        chk("t1_armed_locked", 16'(locked_o), 16'd1);
        chk("t1_armed_viol", 16'(violation_o), 16'd0);
        txn(0, 1'b1, 8'h5A);
        chk("t1_unlocked", 16'(locked_o), 16'd0);
        chk("t1_unl_viol", 16'(violation_o), 16'd0);
        txn(0, 1'b0, 8'h3C);
        chk("t1_reg", 16'(reg_q_o), 16'h3C);
        chk("t1_wr_viol", 16'(violation_o), 16'd0);
        txn(0, 1'b1, 8'h00);
        chk("t1_relock", 16'(locked_o), 16'd1);
        chk("t1_relock_viol", 16'(violation_o), 16'd0);

        // Data write while locked
        txn(1, 1'b0, 8'h77);
        chk("t2_reg", 16'(reg_q_o), 16'h3C);
        chk("t2_viol", 16'(violation_o), 16'd1);
        chk("t2_cnt", 16'(viol_cnt_o), 16'd1);
        step();
        chk("t2_viol_end", 16'(violation_o), 16'd0);

        // Round-robin with both requesting
        req_i = 2'b11;
        key_i = 2'b00;
        data_i = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_rr_gnt", 16'(gnt_o), (i % 2 == 0) ? 16'h1 : 16'h2);
            step();
        end
        req_i = 2'b00;
        chk("t3_cnt", 16'(viol_cnt_o), 16'd5);
        chk("t3_reg", 16'(reg_q_o), 16'h3C);

        // Idle timeout; write at timer = 1 is accepted
        txn(0, 1'b1, 8'hA5);
        txn(0, 1'b1, 8'h5A);
        for (int i = 0; i < 15; i++) step();
        chk("t4_still_unl", 16'(locked_o), 16'd0);
        txn(0, 1'b0, 8'hC3);
        chk("t4_late_wr", 16'(reg_q_o), 16'hC3);
        chk("t4_late_unl", 16'(locked_o), 16'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t4_timeout", 16'(locked_o), (i == 16) ? 16'd1 : 16'd0);
        end
        chk("t4_cnt", 16'(viol_cnt_o), 16'd5);

        // Hard lock racing a data write
        txn(0, 1'b1, 8'hA5);
        txn(0, 1'b1, 8'h5A);
        chk("t5_unl", 16'(locked_o), 16'd0);
        hard_lock_i = 1'b1;
        txn(1, 1'b0, 8'h11);
        hard_lock_i = 1'b0;
        chk("t5_reg", 16'(reg_q_o), 16'hC3);
        chk("t5_hard", 16'(hard_locked_o), 16'd1);
        chk("t5_viol", 16'(violation_o), 16'd1);
        chk("t5_locked", 16'(locked_o), 16'd1);
        chk("t5_cnt", 16'(viol_cnt_o), 16'd6);
        txn(0, 1'b1, 8'hA5);
        chk("t5_k0_viol", 16'(violation_o), 16'd1);
        txn(0, 1'b1, 8'h5A);
        chk("t5_k1_viol", 16'(violation_o), 16'd1);
        chk("t5_k1_locked", 16'(locked_o), 16'd1);
        chk("t5_cnt2", 16'(viol_cnt_o), 16'd8);
        chk("t5_hard_sticky", 16'(hard_locked_o), 16'd1);

        // Clear, saturate the counter, then reset mid-ARMED
        rst_ni = 1'b0;
        #2;
        chk("t6_rst_hard", 16'(hard_locked_o), 16'd0);
        step();
        rst_ni = 1'b1;
        req_i = 2'b01;
        key_i = 2'b00;
        data_i = 16'h0099;
        for (int i = 0; i < 300; i++) step();
        req_i = 2'b00;
        chk("t6_sat", 16'(viol_cnt_o), 16'hFF);
        chk("t6_reg", 16'(reg_q_o), 16'h00);
        txn(0, 1'b1, 8'hA5);
        chk("t6_armed_viol", 16'(violation_o), 16'd0);
        chk("t6_cnt_hold", 16'(viol_cnt_o), 16'hFF);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset();
        step();
        rst_ni = 1'b1;
        txn(0, 1'b1, 8'h5A);
        chk("t6_k1_locked", 16'(locked_o), 16'd1);
        chk("t6_k1_viol", 16'(violation_o), 16'd1);
        chk("t6_k1_cnt", 16'(viol_cnt_o), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
